// File: rtl/m6502_mem_if.sv
// CPU-side bus between the m6502 core (master) and its memory responder (slave).
// Handshake: the master raises cs with wr/address/write_data stable and holds it until
// it has seen mem_ready, which the slave pulses for exactly one cycle per access
// (data_valid pulses with it on reads only). The master must drop cs for at least one
// cycle before the next request; read_data holds until the next read completes.
interface m6502_mem_if;
  logic        cs;
  logic        wr;
  logic [15:0] address;
  logic [7:0]  write_data;
  logic        mem_ready;
  logic        data_valid;
  logic [7:0]  read_data;

  modport master (
    output cs, wr, address, write_data,
    input  mem_ready, data_valid, read_data
  );

  modport slave (
    input  cs, wr, address, write_data,
    output mem_ready, data_valid, read_data
  );
endinterface

// File: rtl/m6502_mem.sv
// Byte-wide synchronous RAM responder for the m6502 bus with programmable wait states
// and a side load port for preloading program memory.
module m6502_mem #(
  parameter int MEM_AWIDTH  = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  m6502_mem_if.slave            bus,
  input  logic                  load_we,
  input  logic [MEM_AWIDTH-1:0] load_addr,
  input  logic [7:0]            load_data,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;
  logic latch_en;
  logic do_access;

  logic                  wr_q;
  logic [MEM_AWIDTH-1:0] addr_q;
  logic [7:0]            wdata_q;
  logic                  ready_q;
  logic                  valid_q;
  logic [7:0]            rdata_q;

  logic [7:0] mem [2**MEM_AWIDTH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // RELEASE waits for cs to fall so a held cs never starts a second access.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    latch_en   = 1'b0;
    do_access  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.cs) begin
          latch_en   = 1'b1;
          cnt_next   = WS_INIT;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          do_access  = 1'b1;
          state_next = S_ACK;
        end
      end
      S_ACK: begin
        state_next = S_RELEASE;
      end
      S_RELEASE: begin
        if (!bus.cs) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      ready_q <= do_access;
      valid_q <= do_access & ~wr_q;
      if (latch_en) begin
        wr_q    <= bus.wr;
        addr_q  <= bus.address[MEM_AWIDTH-1:0];
        wdata_q <= bus.write_data;
      end
      if (do_access && !wr_q) rdata_q <= mem[addr_q];
    end
  end

  // No reset on the array: contents survive reset, and a load on a reset edge still lands.
  // The CPU write is assigned last so it wins an address collision with the load port.
  always_ff @(posedge clk) begin
    if (load_we) mem[load_addr] <= load_data;
    if (reset_n && do_access && wr_q) mem[addr_q] <= wdata_q;
  end

  generate
    if (MEM_AWIDTH < 16) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.address[15:MEM_AWIDTH];
    end
  endgenerate

  assign bus.mem_ready  = ready_q;
  assign bus.data_valid = valid_q;
  assign bus.read_data  = rdata_q;
  assign fsm_state      = state;

endmodule

// File: tb/tb_m6502_mem.sv
// Directed bench for m6502_mem: three instances with WAIT_STATES 0, 3 and 5 sharing one
// clock and one load port, each with its own bus and reset.
module tb_m6502_mem;

  logic        clk;
  logic        load_we;
  logic [11:0] load_addr;
  logic [7:0]  load_data;

  logic        rst_n_a [3];
  logic        cs_a    [3];
  logic        wr_a    [3];
  logic [15:0] addr_a  [3];
  logic [7:0]  wdata_a [3];
  logic        rdy_a   [3];
  logic        dv_a    [3];
  logic [7:0]  rd_a    [3];
  logic [1:0]  st_a    [3];

  int n_checks;
  int n_fail;

  localparam logic [1:0] ST_IDLE = 2'd0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    m6502_mem_if bus ();
    assign bus.cs         = cs_a[g];
    assign bus.wr         = wr_a[g];
    assign bus.address    = addr_a[g];
    assign bus.write_data = wdata_a[g];
    assign rdy_a[g]       = bus.mem_ready;
    assign dv_a[g]        = bus.data_valid;
    assign rd_a[g]        = bus.read_data;

    m6502_mem #(
      .MEM_AWIDTH (12),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 3 : 5))
    ) dut (
      .clk      (clk),
      .reset_n  (rst_n_a[g]),
      .bus      (bus),
      .load_we  (load_we),
      .load_addr(load_addr),
      .load_data(load_data),
      .fsm_state(st_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 5);
  endfunction

  task automatic preload(input logic [11:0] a, input logic [7:0] v);
    @(negedge clk);
    load_we = 1'b1; load_addr = a; load_data = v;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  // One complete bus transaction; optional load-port write lands on the completion edge.
  task automatic access(input int d, input logic w, input logic [15:0] a, input logic [7:0] wd,
                        input logic [7:0] exp_rd, input bit coll, input logic [7:0] cdata,
                        input string name);
    int n;
    bit seen;
    @(negedge clk);
    cs_a[d] = 1'b1; wr_a[d] = w; addr_a[d] = a; wdata_a[d] = wd;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (rdy_a[d]) begin
        seen = 1;
      end else begin
        if (n == 1) begin
          addr_a[d] = ~a; wdata_a[d] = ~wd; wr_a[d] = ~w;
        end
        if (coll && n == ws_of(d) + 1) begin
          load_we = 1'b1; load_addr = a[11:0]; load_data = cdata;
        end else begin
          load_we = 1'b0;
        end
      end
    end
    load_we = 1'b0;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout: mem_ready not seen in %0d cycles, required within %0d", name, n, ws_of(d) + 1);
    end
    n_checks++;
    if (n - 1 !== ws_of(d) + 1) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges, required %0d", name, n - 1, ws_of(d) + 1);
    end
    n_checks++;
    if (dv_a[d] !== ~w) begin
      n_fail++;
      $display("FAIL %s data_valid: got %b, required %b", name, dv_a[d], ~w);
    end
    n_checks++;
    if (rd_a[d] !== exp_rd) begin
      n_fail++;
      $display("FAIL %s read_data: got %h, required %h", name, rd_a[d], exp_rd);
    end
    @(negedge clk);
    n_checks++;
    if (rdy_a[d] !== 1'b0 || dv_a[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s strobe_clear: got ready=%b valid=%b, required 0 0", name, rdy_a[d], dv_a[d]);
    end
    cs_a[d] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (st_a[d] !== ST_IDLE) begin
      n_fail++;
      $display("FAIL %s back_to_idle: got state %0d, required %0d", name, st_a[d], ST_IDLE);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      rst_n_a[d] = 1'b0; cs_a[d] = 1'b0; wr_a[d] = 1'b0; addr_a[d] = 16'h0; wdata_a[d] = 8'h0;
    end
    load_we = 1'b0; load_addr = 12'h0; load_data = 8'h0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (rdy_a[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b, required 0", d, rdy_a[d]); end
      n_checks++;
      if (dv_a[d] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b, required 0", d, dv_a[d]); end
      n_checks++;
      if (rd_a[d] !== 8'h00) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h, required 00", d, rd_a[d]); end
      n_checks++;
      if (st_a[d] !== ST_IDLE) begin n_fail++; $display("FAIL reset_state[%0d]: got %0d, required 0", d, st_a[d]); end
      rst_n_a[d] = 1'b1;
    end
  endtask

  task automatic test_read_ws0();
    access(0, 1'b0, 16'h0005, 8'h00, 8'hA9, 0, 8'h00, "read_ws0");
  endtask

  task automatic test_write_read_ws3();
    access(1, 1'b1, 16'h0123, 8'h3C, 8'h00, 0, 8'h00, "write_ws3");
    access(1, 1'b0, 16'h0123, 8'h00, 8'h3C, 0, 8'h00, "read_ws3");
  endtask

  task automatic test_alias();
    access(0, 1'b1, 16'h1005, 8'h77, 8'hA9, 0, 8'h00, "alias_write");
    access(0, 1'b0, 16'h0005, 8'h00, 8'h77, 0, 8'h00, "alias_read");
  endtask

  task automatic test_cs_held();
    int pulses;
    bit seen;
    @(negedge clk);
    cs_a[0] = 1'b1; wr_a[0] = 1'b0; addr_a[0] = 16'h0005;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (rdy_a[0]) pulses++;
    end
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL cs_held_pulses: got %0d, required 1", pulses); end
    n_checks++;
    if (rd_a[0] !== 8'h77) begin n_fail++; $display("FAIL cs_held_rdata: got %h, required 77", rd_a[0]); end
    cs_a[0] = 1'b0;
    @(negedge clk);
    cs_a[0] = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rdy_a[0]) seen = 1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL cs_rearm: mem_ready got 0 within 20 cycles, required 1"); end
    @(negedge clk);
    cs_a[0] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_wait();
    int pulses;
    @(negedge clk);
    cs_a[2] = 1'b1; wr_a[2] = 1'b1; addr_a[2] = 16'h0010; wdata_a[2] = 8'hFF;
    pulses = 0;
    @(negedge clk);
    if (rdy_a[2]) pulses++;
    @(negedge clk);
    if (rdy_a[2]) pulses++;
    rst_n_a[2] = 1'b0; cs_a[2] = 1'b0;
    load_we = 1'b1; load_addr = 12'h030; load_data = 8'h5A;
    @(negedge clk);
    rst_n_a[2] = 1'b1; load_we = 1'b0;
    n_checks++;
    if (st_a[2] !== ST_IDLE) begin n_fail++; $display("FAIL reset_wait_state: got %0d, required 0", st_a[2]); end
    for (int i = 0; i < 10; i++) begin
      if (rdy_a[2]) pulses++;
      @(negedge clk);
    end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL reset_wait_pulses: got %0d, required 0", pulses); end
    access(2, 1'b0, 16'h0010, 8'h00, 8'h00, 0, 8'h00, "reset_wait_read");
    access(2, 1'b0, 16'h0030, 8'h00, 8'h5A, 0, 8'h00, "reset_edge_load");
  endtask

  task automatic test_collision();
    access(0, 1'b1, 16'h0020, 8'h22, 8'h77, 1, 8'h11, "coll_write");
    access(0, 1'b0, 16'h0020, 8'h00, 8'h22, 1, 8'h33, "coll_read_old");
    access(0, 1'b0, 16'h0020, 8'h00, 8'h33, 0, 8'h00, "coll_read_new");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    preload(12'h005, 8'hA9);
    preload(12'h010, 8'h00);
    preload(12'h123, 8'h00);
    test_read_ws0();
    test_write_read_ws3();
    test_alias();
    test_cs_held();
    test_reset_wait();
    test_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
